// File: rtl/store_buffer.sv
// store_buffer: store-queueing front end for the MIPS data memory.
// Stores wait in a small FIFO and drain to memory one per cycle while the port
// is free; loads forward from the youngest matching queued store or read memory.
//
// Ports:
//   CLK, reset      clock, asynchronous active-high reset
//   req_*           MEM-stage request (valid/write/addr/wdata) and req_ready
//   load_valid      one-cycle pulse, load_data holds the registered result
//   empty           no stores queued
//   mem_*           data memory port (address, write data, write enable, read
//                   strobe) and mem_readData returned in the same cycle
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, LD_GAP} state_t;

    state_t            state, nextState;
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              acceptStore, acceptLoad, loadMiss, drain;
    logic              fwdHit;
    logic [DATA_W-1:0] fwdData;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // The gap cycle after every accepted load keeps mem_memRead from being
    // asserted in two consecutive cycles.
    always_comb begin
        nextState = state;
        if (state == LD_GAP)  nextState = IDLE;
        else if (acceptLoad)  nextState = LD_GAP;
    end

    // Scan from oldest to youngest so the last match wins; entry k is valid
    // when its distance from head is below count, which handles pointer wrap.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count && addrQ[head + PTR_W'(k)] == req_addr) begin
                fwdHit  = 1'b1;
                fwdData = dataQ[head + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        req_ready     = (state == IDLE) && (!req_write || count < CNT_W'(DEPTH));
        acceptStore   = req_valid && req_ready && req_write;
        acceptLoad    = req_valid && req_ready && !req_write;
        loadMiss      = acceptLoad && !fwdHit;
        drain         = (count != '0) && !loadMiss;
        mem_memRead   = loadMiss;
        mem_memWrite  = drain;
        mem_address   = loadMiss ? req_addr : drain ? addrQ[head] : '0;
        mem_writeData = drain ? dataQ[head] : '0;
        empty         = (count == '0);
    end

    // Entry storage needs no reset: count gates every use of it.
    always_ff @(posedge CLK) begin
        if (acceptStore) begin
            addrQ[tail] <= req_addr;
            dataQ[tail] <= req_wdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
        end else begin
            if (acceptStore) tail <= tail + 1'b1;
            if (drain)       head <= head + 1'b1;
            count      <= count + CNT_W'(acceptStore) - CNT_W'(drain);
            load_valid <= acceptLoad;
            if (acceptLoad) load_data <= fwdHit ? fwdData : mem_readData;
        end
    end

endmodule
